// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receive types and constants
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
    localparam int FRAME_BITS = 11;
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-flop synchroniser plus consecutive-sample debounce
module ps2_line_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_filt
);
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    // synchronise, then change level only after FILTER_CYCLES differing samples in a row
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync   <= 2'b11;
            cnt    <= '0;
            o_filt <= 1'b1;
        end else begin
            sync <= {sync[0], i_pin};
            if (sync[1] == o_filt)
                cnt <= '0;
            else if (cnt == CW'(FILTER_CYCLES - 1)) begin
                o_filt <= sync[1];
                cnt    <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ps2_receive.sv
// ps2_receive: PS/2 device-to-host frame deserialiser with error and timeout detection
module ps2_receive
    import ps2_pkg::*;
#(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(FRAME_BITS);
    logic                   clk_filt, clk_prev, fall;
    logic [FILTER_CYCLES+1:0] dline;
    logic                   data;
    ps2_state_t             state;
    logic [BW-1:0]          count;
    logic [7:0]             shreg;
    logic                   par;
    logic [TW-1:0]          tcnt;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filt (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_pin  (i_ps2_clk),
        .o_filt (clk_filt)
    );

    assign data = dline[FILTER_CYCLES+1];

    // data line delayed by sync + filter depth so it stays aligned with the filtered clock
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) dline <= '1;
        else          dline <= {dline[FILTER_CYCLES:0], i_ps2_data};
    end

    // registered falling-edge strobe of the filtered clock
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_prev <= 1'b1;
            fall     <= 1'b0;
        end else begin
            clk_prev <= clk_filt;
            fall     <= clk_prev & ~clk_filt;
        end
    end

    // frame FSM with registered outputs; a fall beats a coincident timeout
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            count   <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            tcnt    <= '0;
            o_byte  <= '0;
            o_valid <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            if (state == IDLE || fall)
                tcnt <= '0;
            else if (tcnt != TW'(TIMEOUT_CYCLES))
                tcnt <= tcnt + 1'b1;
            if (fall) begin
                case (state)
                    IDLE: if (!data) begin
                        state <= DATA;
                        count <= '0;
                    end
                    DATA: begin
                        shreg[count[2:0]] <= data;
                        count             <= count + 1'b1;
                        if (count == BW'(7)) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= data;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (data && ^{shreg, par}) begin
                            o_byte  <= shreg;
                            o_valid <= 1'b1;
                        end else
                            o_err <= 1'b1;
                    end
                endcase
            end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES)) begin
                o_err <= 1'b1;
                state <= IDLE;
                count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_receive.sv
// tb_ps2_receive: scoreboard bench for the PS/2 receiver
module tb_ps2_receive;
    import ps2_pkg::*;
    localparam int F  = 8;
    localparam int TO = 500;
    localparam int H  = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] o_byte;
    logic       o_valid, o_err;

    typedef struct {
        logic       err;
        logic [7:0] byt;
        logic       lat;
    } exp_t;

    exp_t       q[$];
    int         errors = 0, checks = 0, cyc = 0, fall_cyc = 0;
    logic [7:0] last_good = 8'h00;

    always #5 clk = ~clk;

    ps2_receive #(.FILTER_CYCLES(F), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_ps2_clk (ps2_clk),
        .i_ps2_data(ps2_data),
        .o_byte    (o_byte),
        .o_valid   (o_valid),
        .o_err     (o_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // drive nbits of a frame; the full 11-bit frame queues its expected outcome before the stop fall
    task automatic send(input logic [7:0] d, input logic bad_par, input logic stop,
                        input int nbits, input logic glitch);
        logic [10:0] b;
        b = {stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = b[i];
            clks(H / 2);
            if (glitch) begin
                ps2_clk = 1'b0;
                clks(3);
                ps2_clk = 1'b1;
            end
            clks(H / 2);
            if (i == 10) begin
                if (!stop || bad_par) q.push_back('{1'b1, last_good, 1'b1});
                else begin
                    q.push_back('{1'b0, d, 1'b1});
                    last_good = d;
                end
            end
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            clks(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        clks(H);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && q.size() != 0; i++) clks(1);
        check(tag, q.size(), 0);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && (o_valid || o_err)) begin
            if (q.size() == 0)
                check("spurious", {30'd0, o_valid, o_err}, 0);
            else begin
                automatic exp_t e = q.pop_front();
                check("err", o_err, e.err);
                check("valid", o_valid, !e.err);
                check("byte", o_byte, e.byt);
                if (e.lat) check("latency", cyc - fall_cyc, F + 4);
            end
        end
    end

    initial begin
        clks(3);
        check("rst_byte", o_byte, 0);
        check("rst_valid", o_valid, 0);
        check("rst_err", o_err, 0);
        rst_n = 1'b1;
        clks(5);
        send(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        drain("drain_1c");
        send(PS2_BREAK, 1'b0, 1'b1, 11, 1'b0);
        send(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        drain("drain_f0_1c");
        send(8'h1C, 1'b1, 1'b1, 11, 1'b0);
        drain("drain_bad_par");
        send(8'h55, 1'b0, 1'b0, 11, 1'b0);
        drain("drain_bad_stop");
        send(8'hAA, 1'b0, 1'b1, 6, 1'b0);
        q.push_back('{1'b1, last_good, 1'b0});
        clks(TO + 50);
        drain("drain_timeout");
        send(8'h32, 1'b0, 1'b1, 11, 1'b0);
        drain("drain_32");
        for (int i = 0; i < 3; i++) begin
            ps2_clk = 1'b0;
            clks(3);
            ps2_clk = 1'b1;
            clks(H);
            ps2_clk = 1'b0;
            clks(H);
            ps2_clk = 1'b1;
            clks(H);
        end
        send(8'h5A, 1'b0, 1'b1, 11, 1'b1);
        drain("drain_5a");
        send(8'h77, 1'b0, 1'b1, 5, 1'b0);
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        clks(4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_byte", o_byte, 0);
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_err", o_err, 0);
        last_good = 8'h00;
        clks(2);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        clks(30);
        rst_n = 1'b1;
        clks(5);
        send(8'h12, 1'b0, 1'b1, 11, 1'b0);
        drain("drain_12");
        clks(50);
        check("final_byte", o_byte, last_good);
        check("final_queue", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_receive.md
Name: ps2_receive

Overview:
- Deserialises PS/2 keyboard frames (device-to-host) into 8-bit scan codes.
- Sits directly upstream of the UART transmit/scan-code translator. o_byte/o_valid drive its i_to_send/i_send.
- Syncs and deglitches the PS/2 clock and data pins, checks start/parity/stop bits, and recovers from truncated frames with an inter-edge timeout.

Parameters:
- FILTER_CYCLES, 8: consecutive identical synchronized samples required before the filtered PS/2 clock changes level.
- TIMEOUT_CYCLES, 20000: system clocks without a filtered falling edge before a partial frame is abandoned (200 us at 100 MHz).

Ports:
- i_clk  in  1  system clock (100 MHz)
- i_rst_n  in  1  asynchronous active-low reset
- i_ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- i_ps2_data  in  1  raw PS/2 data pin, asynchronous
- o_byte  out  8  last good scan code; held until the next good frame
- o_valid  out  1  one-cycle pulse: o_byte updated this cycle
- o_err  out  1  one-cycle pulse: parity, stop or timeout error

Behaviour:
- Reset is async on i_rst_n low.
  - Outputs: o_byte=0, o_valid=0, o_err=0.
  - Internal: state=IDLE, filtered clk=1, sync flops=1, bit count=0, timeout count=0.
- Deassertion is used as-is, with no internal reset synchroniser beyond the flops.
- Input conditioning:
  - Each pin passes through a 2-flop synchroniser.
  - Filtered clk takes the synchronized clk value only after FILTER_CYCLES consecutive samples differ from the current filtered value. Any matching sample clears the counter, so glitches shorter than FILTER_CYCLES are ignored.
- Edge strobe:
  - Registered fall = prev_filtered & ~filtered.
  - On that strobe, the synchronized data is delayed by the same FILTER_CYCLES to stay aligned, then sampled.
- Latency: raw pin falling edge to o_valid/o_err is exactly FILTER_CYCLES+4 clocks, broken down as follows.
  - 2 clocks for the synchroniser.
  - FILTER_CYCLES for the filter.
  - 1 clock for the edge register.
  - 1 clock for the FSM output register.
- Frame: 11 bits, falling-edge sampled: start(0), d0..d7 LSB first, odd parity, stop(1).
- FSM:
  - IDLE: on fall, if data=0, go to DATA with count=0. If data=1, stay in IDLE silently (false start).
  - DATA: on fall, shift data into bit[count] and increment count. After count=7 is sampled, go to PARITY.
  - PARITY: on fall, store the parity bit and go to STOP.
  - STOP: on fall, check the frame and return to IDLE.
    - If data=1 and ^{d7..d0,parity}==1, load o_byte and pulse o_valid.
    - Otherwise pulse o_err; o_byte is unchanged.
- Timeout:
  - Counter clears on every fall and whenever state=IDLE; it increments otherwise and saturates.
  - At TIMEOUT_CYCLES in a non-IDLE state: pulse o_err, go to IDLE, clear count. A fall in the same cycle takes priority and is processed normally.
- o_valid and o_err are never high together, and each is high for exactly one cycle per frame.
- Back-to-back frames need no gap beyond the PS/2 protocol. A new start edge is accepted the cycle after returning to IDLE.
- Reset mid-frame aborts immediately with no pulse. The next frame decodes normally.
- Prefix codes E0/F0 are passed through unmodified; interpretation is downstream.

Decomposition:
- Shared package ps2_pkg holds:
  - the FSM state encoding (IDLE, DATA, PARITY, STOP);
  - FRAME_BITS=11;
  - PS/2 prefix constants PS2_EXT=8'hE0 and PS2_BREAK=8'hF0, also used by downstream stages.
- One sub-module, ps2_line_filter: 2-flop synchroniser plus FILTER_CYCLES debounce, parameterised.
  - Instantiated for the clock line.
  - The data line uses an equal-delay sync/delay line so alignment holds.

Test Plan:
- Frame 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1; parity 0) at 12.5 kHz -> o_byte=8'h1C, o_valid high 1 cycle, exactly FILTER_CYCLES+4 clocks after the stop-bit falling edge, o_err=0.
- Sequence F0 then 1C back-to-back (F0 parity 1) -> two o_valid pulses with o_byte=8'hF0 then 8'h1C; matches downstream release handling.
- Frame 0x1C with parity forced to 1 -> o_err pulse, no o_valid, o_byte keeps its previous value. Frame with stop=0 -> o_err likewise.
- Stop the PS/2 clock after 5 data bits for >TIMEOUT_CYCLES -> o_err pulse at timeout, state back to IDLE. A following 0x32 frame -> o_valid, o_byte=8'h32.
- Inject 3-clock low glitches on i_ps2_clk mid-bit and data=1 idle-level falls -> no bit consumed, no false start. The subsequent 0x5A frame decodes correctly.
- Assert i_rst_n low during bit 4 -> outputs 0 immediately. After release, frame 0x12 -> o_valid, o_byte=8'h12.
